// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches one or two 16-bit words per instruction,
// issues them on a valid/ready handshake, and handles redirects and halt (SEQ_HALT_RESUME_EN).
module fetch_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instr,
    input  logic              is_double_word,
    input  logic              is_halt,
    output logic [15:0]       imm,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [ADDR_W-1:0] issue_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH_LO,
        S_CHECK,
        S_FETCH_HI,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t            r_state, w_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_issue_pc, w_issue_pc;
    logic [15:0]       r_instr, w_instr;
    logic [15:0]       r_imm, w_imm;
    logic              r_req, w_req;
    logic              r_flush, w_flush;
    logic              r_halted, w_halted;
    logic              w_ack;
    logic              w_load_addr;

    // An ack only counts while a request is actually outstanding.
    assign w_ack = r_req & mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH_LO;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_pc       = r_pc;
        w_flush    = r_flush;
        w_instr    = r_instr;
        w_imm      = r_imm;
        w_issue_pc = r_issue_pc;
        w_halted   = r_halted;
        case (r_state)
            S_FETCH_LO, S_FETCH_HI: begin
                if (w_ack) begin
                    if (redirect) begin
                        w_pc    = redirect_pc;
                        w_flush = 1'b0;
                        w_nxt   = S_FETCH_LO;
                    end else if (r_flush) begin
                        w_flush = 1'b0;
                        w_nxt   = S_FETCH_LO;
                    end else if (r_state == S_FETCH_LO) begin
                        w_instr    = mem_rdata;
                        w_issue_pc = r_addr;
                        w_pc       = r_addr + ADDR_W'(2);
                        w_nxt      = S_CHECK;
                    end else begin
                        w_imm = mem_rdata;
                        w_pc  = r_addr + ADDR_W'(2);
                        w_nxt = S_ISSUE;
                    end
                end else if (redirect) begin
                    // Request in flight must complete untouched; its data is dropped.
                    w_pc    = redirect_pc;
                    w_flush = r_req;
                end
            end
            S_CHECK: begin
                if (redirect) begin
                    w_pc  = redirect_pc;
                    w_nxt = S_FETCH_LO;
                end else if (is_halt) begin
                    w_halted = 1'b1;
                    w_nxt    = S_HALT;
                end else if (is_double_word) begin
                    w_nxt = S_FETCH_HI;
                end else begin
                    w_imm = 16'h0000;
                    w_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (redirect) begin
                    w_pc  = redirect_pc;
                    w_nxt = S_FETCH_LO;
                end else if (issue_ready) begin
                    w_nxt = S_FETCH_LO;
                end
            end
            S_HALT: begin
`ifdef SEQ_HALT_RESUME_EN
                if (redirect) begin
                    w_halted = 1'b0;
                    w_pc     = redirect_pc;
                    w_nxt    = S_FETCH_LO;
                end
`endif
            end
            default: w_nxt = S_FETCH_LO;
        endcase
        w_pc[0] = 1'b0;
    end

    assign w_req = (w_nxt == S_FETCH_LO) || (w_nxt == S_FETCH_HI);
    // Address may only move when no request is pending or the pending one completes.
    assign w_load_addr = w_req && !(r_req && !w_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_issue_pc <= RESET_PC;
            r_instr    <= 16'h0000;
            r_imm      <= 16'h0000;
            r_req      <= 1'b0;
            r_flush    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_pc       <= w_pc;
            r_issue_pc <= w_issue_pc;
            r_instr    <= w_instr;
            r_imm      <= w_imm;
            r_req      <= w_req;
            r_flush    <= w_flush;
            r_halted   <= w_halted;
            if (w_load_addr) r_addr <= w_pc;
        end
    end

    assign mem_req     = r_req;
    assign mem_addr    = r_addr;
    assign instr       = r_instr;
    assign imm         = r_imm;
    assign issue_pc    = r_issue_pc;
    assign issue_valid = (r_state == S_ISSUE);
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, single/double-word fetch, stalls,
// redirects with flush, pc wrap and halt (resume checked when SEQ_HALT_RESUME_EN is set).
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instr;
    logic        is_double_word;
    logic        is_halt;
    logic [15:0] imm;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] issue_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .is_double_word (is_double_word),
        .is_halt        (is_halt),
        .imm            (imm),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_pc       (issue_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    // Toy decoder: opcode 0xD is double-word, 0xFFFF is SYS_END.
    assign is_double_word = (instr[15:12] == 4'hD);
    assign is_halt        = (instr == 16'hFFFF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5555;
        issue_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        tick(); tick(); tick();
        chk("rst_req",    {15'd0, mem_req}, 16'd0);
        chk("rst_addr",   mem_addr, 16'h0000);
        chk("rst_valid",  {15'd0, issue_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_instr",  instr, 16'h0000);
        chk("rst_imm",    imm, 16'h0000);
        chk("rst_ipc",    issue_pc, 16'h0000);

        // Release with ack still high: the stray ack must be ignored.
        rst_n = 1'b1;
        tick();
        chk("rel_req",  {15'd0, mem_req}, 16'd1);
        chk("rel_addr", mem_addr, 16'h0000);

        // Single-word fetch, immediate ack.
        mem_rdata = 16'h1248;
        tick();
        mem_ack = 1'b0;
        chk("sw_req_drop", {15'd0, mem_req}, 16'd0);
        chk("sw_valid_early", {15'd0, issue_valid}, 16'd0);
        tick();
        chk("sw_valid", {15'd0, issue_valid}, 16'd1);
        chk("sw_instr", instr, 16'h1248);
        chk("sw_imm",   imm, 16'h0000);
        chk("sw_ipc",   issue_pc, 16'h0000);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("sw_next_req",  {15'd0, mem_req}, 16'd1);
        chk("sw_next_addr", mem_addr, 16'h0002);

        // Double-word: opcode word at 0x0002, immediate 0xBEEF at 0x0004 acked late.
        mem_ack = 1'b1; mem_rdata = 16'hD123;
        tick();
        mem_ack = 1'b0;
        chk("dw_check_req", {15'd0, mem_req}, 16'd0);
        tick();
        chk("dw_hi_req",  {15'd0, mem_req}, 16'd1);
        chk("dw_hi_addr", mem_addr, 16'h0004);
        tick();
        chk("dw_wait1_addr", mem_addr, 16'h0004);
        tick();
        chk("dw_wait2_addr", mem_addr, 16'h0004);
        chk("dw_wait2_req",  {15'd0, mem_req}, 16'd1);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        chk("dw_valid", {15'd0, issue_valid}, 16'd1);
        chk("dw_instr", instr, 16'hD123);
        chk("dw_imm",   imm, 16'hBEEF);
        chk("dw_ipc",   issue_pc, 16'h0002);

        // Execute stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {15'd0, issue_valid}, 16'd1);
            chk("stall_instr", instr, 16'hD123);
            chk("stall_imm",   imm, 16'hBEEF);
            chk("stall_req",   {15'd0, mem_req}, 16'd0);
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("stall_next_req",  {15'd0, mem_req}, 16'd1);
        chk("stall_next_addr", mem_addr, 16'h0006);

        // Redirect coinciding with ack: word dropped, refetch at 0x0010.
        mem_ack = 1'b1; mem_rdata = 16'h7777; redirect = 1'b1; redirect_pc = 16'h0010;
        tick();
        mem_ack = 1'b0; redirect = 1'b0;
        chk("rdack_addr",  mem_addr, 16'h0010);
        chk("rdack_req",   {15'd0, mem_req}, 16'd1);
        chk("rdack_instr", instr, 16'hD123);

        // Redirect while a fetch waits 3 cycles for ack.
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("flush_addr1", mem_addr, 16'h0010);
        tick();
        chk("flush_addr2", mem_addr, 16'h0010);
        tick();
        chk("flush_addr3", mem_addr, 16'h0010);
        chk("flush_req3",  {15'd0, mem_req}, 16'd1);
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        tick();
        chk("flush_new_addr", mem_addr, 16'h0040);
        chk("flush_new_req",  {15'd0, mem_req}, 16'd1);
        chk("flush_instr",    instr, 16'hD123);
        chk("flush_valid",    {15'd0, issue_valid}, 16'd0);
        mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("post_flush_valid", {15'd0, issue_valid}, 16'd1);
        chk("post_flush_instr", instr, 16'h1111);
        chk("post_flush_imm",   imm, 16'h0000);
        chk("post_flush_ipc",   issue_pc, 16'h0040);

        // Redirect in ISSUE without ready drops the instruction; pc wraps at 0xFFFE.
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        chk("drop_valid", {15'd0, issue_valid}, 16'd0);
        chk("drop_addr",  mem_addr, 16'hFFFE);
        mem_ack = 1'b1; mem_rdata = 16'h3333;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("wrap_ipc",   issue_pc, 16'hFFFE);
        chk("wrap_instr", instr, 16'h3333);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("wrap_addr", mem_addr, 16'h0000);

        // SYS_END.
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("halt_flag",  {15'd0, halted}, 16'd1);
        chk("halt_req",   {15'd0, mem_req}, 16'd0);
        chk("halt_valid", {15'd0, issue_valid}, 16'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_hold_flag", {15'd0, halted}, 16'd1);
            chk("halt_hold_req",  {15'd0, mem_req}, 16'd0);
        end
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
`ifdef SEQ_HALT_RESUME_EN
        chk("resume_flag", {15'd0, halted}, 16'd0);
        chk("resume_req",  {15'd0, mem_req}, 16'd1);
        chk("resume_addr", mem_addr, 16'h0100);
`else
        chk("noresume_flag", {15'd0, halted}, 16'd1);
        chk("noresume_req",  {15'd0, mem_req}, 16'd0);
        tick();
        chk("noresume_flag2", {15'd0, halted}, 16'd1);
        chk("noresume_req2",  {15'd0, mem_req}, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
